fifo_sc_prog: RTL and testbench

- Single-clock, parametrised FIFO. Next generation of the team's small synchronous FIFO.
- Adds the following over the previous generation:
  - arbitrary (non-power-of-2) depth
  - runtime-programmable almost-full/almost-empty thresholds
  - an occupancy level output
  - synchronous flush
  - sticky overflow/underflow error flags
  - a full-cycle read+write pass-through
- Used between SoC bus peripherals (UART, SPI, DMA staging) and the core-side register interface.

---
 rtl/fifo_sc_prog.sv | 164 ++++++++++++++++
 tb/tb_fifo_sc_prog.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_prog.sv
// fifo_sc_prog: single-clock FIFO with any depth, programmable thresholds,
// occupancy level, synchronous flush, sticky error flags and read+write pass-through.
//
// Parameters
//   WIDTH      data word width
//   DEPTH      storage entries (2..1024, any integer)
//   SHOW_AHEAD 1: head entry always on q; 0: q loads one cycle after an accepted read
//   LW         width of level / threshold ports (derived)
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  synchronous discard of all contents (beats wen/ren)
//   wen, data              write request and write data
//   ren, q                 read request and registered read data
//   af_thresh, ae_thresh   almost-full / almost-empty thresholds, 0 disables
//   level                  current entry count 0..DEPTH
//   full, empty            count == DEPTH / count == 0
//   almost_full            level >= af_thresh (threshold nonzero)
//   almost_empty           level <= ae_thresh (threshold nonzero)
//   err_clr                clears the sticky error flags
//   overflow, underflow    sticky: write dropped / read requested while empty
module fifo_sc_prog #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 6,
    parameter int SHOW_AHEAD = 1,
    parameter int LW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    input  logic [LW-1:0]    af_thresh,
    input  logic [LW-1:0]    ae_thresh,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L    = LW'(1);
    localparam logic [LW-1:0] TWO_L    = LW'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_inc;
    logic [PW-1:0]    wr_ptr_inc;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] q_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             rd_ok;
    logic             wr_ok;
    logic             ovf_set;
    logic             udf_set;

    // Status flags are decoded straight from the registered count.
    assign empty        = (level_reg == '0);
    assign full         = (level_reg == DEPTH_L);
    assign level        = level_reg;
    assign almost_full  = (af_thresh != '0) && (level_reg >= af_thresh);
    assign almost_empty = (ae_thresh != '0) && (level_reg <= ae_thresh);
    assign q            = q_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok   = ren && !empty && !flush;
    assign wr_ok   = wen && !flush && (!full || rd_ok);
    assign ovf_set = wen && !wr_ok && !flush;
    assign udf_set = ren && empty && !flush;

    // Wrap by explicit compare so non-power-of-2 depths work.
    assign rd_ptr_inc = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + PW'(1);
    assign wr_ptr_inc = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + PW'(1);

    // Storage: plain array, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (rd_ok) rd_ptr_reg <= rd_ptr_inc;
            if (wr_ok) wr_ptr_reg <= wr_ptr_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= '0;
        end else if (flush) begin
            level_reg <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + ONE_L;
                2'b01:   level_reg <= level_reg - ONE_L;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // A new error event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (ovf_set)      overflow_reg <= 1'b1;
            else if (err_clr) overflow_reg <= 1'b0;
            if (udf_set)      underflow_reg <= 1'b1;
            else if (err_clr) underflow_reg <= 1'b0;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // q tracks the head entry. rd_ok/wr_ok are already false during
            // flush, so q simply holds (its value is don't-care while empty).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (empty && wr_ok) begin
                    q_reg <= data;
                end else if (rd_ok && (level_reg >= TWO_L)) begin
                    q_reg <= mem[rd_ptr_inc];
                end else if (rd_ok && wr_ok) begin
                    // Single entry leaving while a new one arrives: the
                    // incoming word becomes the head.
                    q_reg <= data;
                end
            end
        end else begin : g_registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (rd_ok) begin
                    q_reg <= mem[rd_ptr_reg];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sc_prog.sv
// Directed bench for fifo_sc_prog. Two instances (show-ahead and registered
// read) share the same stimulus; each task drives one scenario and checks inline.
module tb_fifo_sc_prog;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       wen;
    logic       ren;
    logic [7:0] data;
    logic [2:0] af_thresh;
    logic [2:0] ae_thresh;
    logic       err_clr;

    logic [7:0] q_a, q_b;
    logic [2:0] level_a, level_b;
    logic       full_a, full_b, empty_a, empty_b;
    logic       almost_full_a, almost_full_b, almost_empty_a, almost_empty_b;
    logic       overflow_a, overflow_b, underflow_a, underflow_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_wrap [9] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h21, 8'h22, 8'h23};
    logic [7:0] exp_pass [6] = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'hAA};

    fifo_sc_prog #(.WIDTH(8), .DEPTH(6), .SHOW_AHEAD(1)) u_sa (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .ren(ren), .data(data),
        .q(q_a), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level_a),
        .full(full_a), .empty(empty_a), .almost_full(almost_full_a),
        .almost_empty(almost_empty_a), .err_clr(err_clr),
        .overflow(overflow_a), .underflow(underflow_a)
    );

    fifo_sc_prog #(.WIDTH(8), .DEPTH(6), .SHOW_AHEAD(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .ren(ren), .data(data),
        .q(q_b), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level_b),
        .full(full_b), .empty(empty_b), .almost_full(almost_full_b),
        .almost_empty(almost_empty_b), .err_clr(err_clr),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    // One clock cycle with the given requests; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wen  = w;
        ren  = r;
        data = d;
        @(posedge clk);
        #1;
        wen  = 1'b0;
        ren  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wen = 1'b0; ren = 1'b0; data = '0;
        err_clr = 1'b0; af_thresh = 3'd5; ae_thresh = 3'd1;
        #12;
        rst_n = 1'b1;
        #1;
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_a); end
        checks++; if (almost_empty_a !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", almost_empty_a); end
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_a); end
        checks++; if (q_a !== 8'h00) begin errors++; $display("FAIL reset_q_a got %h exp 00", q_a); end
        checks++; if (q_b !== 8'h00) begin errors++; $display("FAIL reset_q_b got %h exp 00", q_b); end
        checks++; if ({full_a, almost_full_a, overflow_a, underflow_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {full_a, almost_full_a, overflow_a, underflow_a}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h11 + i));
            checks++; if (level_a !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level_a, i + 1); end
            checks++; if (q_a !== 8'h11) begin errors++; $display("FAIL fill_q_head[%0d] got %h exp 11", i, q_a); end
            checks++; if (almost_empty_a !== (i == 0)) begin errors++; $display("FAIL fill_almost_empty[%0d] got %b exp %b", i, almost_empty_a, (i == 0)); end
            checks++; if (almost_full_a !== (i >= 4)) begin errors++; $display("FAIL fill_almost_full[%0d] got %b exp %b", i, almost_full_a, (i >= 4)); end
            checks++; if (full_a !== (i == 5)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full_a, (i == 5)); end
        end
    endtask

    task automatic test_overflow_wrap();
        cyc(1'b1, 1'b0, 8'h77);
        checks++; if (overflow_a !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_a); end
        checks++; if (level_a !== 3'd6) begin errors++; $display("FAIL ovf_level got %0d exp 6", level_a); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (q_a !== exp_wrap[k]) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", k, q_a, exp_wrap[k]); end
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (q_b !== exp_wrap[k]) begin errors++; $display("FAIL wrap_read[%0d] got %h exp %h", k, q_b, exp_wrap[k]); end
        end
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'(8'h21 + k));
        checks++; if (level_a !== 3'd6) begin errors++; $display("FAIL wrap_refill_level got %0d exp 6", level_a); end
        for (int k = 3; k < 9; k++) begin
            checks++; if (q_a !== exp_wrap[k]) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", k, q_a, exp_wrap[k]); end
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (q_b !== exp_wrap[k]) begin errors++; $display("FAIL wrap_read[%0d] got %h exp %h", k, q_b, exp_wrap[k]); end
        end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty_a); end
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_a); end
    endtask

    task automatic test_pass_through();
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 8'(8'h31 + k));
        cyc(1'b1, 1'b1, 8'hAA);
        checks++; if (level_a !== 3'd6) begin errors++; $display("FAIL pass_level got %0d exp 6", level_a); end
        checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL pass_full got %b exp 1", full_a); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL pass_overflow got %b exp 0", overflow_a); end
        checks++; if (q_b !== 8'h31) begin errors++; $display("FAIL pass_read0 got %h exp 31", q_b); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (q_a !== exp_pass[k]) begin errors++; $display("FAIL pass_head[%0d] got %h exp %h", k, q_a, exp_pass[k]); end
            cyc(1'b0, 1'b1, 8'h00);
            checks++; if (q_b !== exp_pass[k]) begin errors++; $display("FAIL pass_read[%0d] got %h exp %h", k, q_b, exp_pass[k]); end
        end
    endtask

    task automatic test_bypass();
        cyc(1'b1, 1'b0, 8'h42);
        checks++; if (q_a !== 8'h42) begin errors++; $display("FAIL byp_first got %h exp 42", q_a); end
        cyc(1'b1, 1'b1, 8'h99);
        checks++; if (q_a !== 8'h99) begin errors++; $display("FAIL byp_q got %h exp 99", q_a); end
        checks++; if (level_a !== 3'd1) begin errors++; $display("FAIL byp_level got %0d exp 1", level_a); end
        checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL byp_empty got %b exp 0", empty_a); end
        checks++; if (q_b !== 8'h42) begin errors++; $display("FAIL byp_read got %h exp 42", q_b); end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (q_b !== 8'h99) begin errors++; $display("FAIL byp_read2 got %h exp 99", q_b); end
    endtask

    task automatic test_underflow_clear();
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (underflow_b !== 1'b1) begin errors++; $display("FAIL udf_set got %b exp 1", underflow_b); end
        checks++; if (q_b !== 8'h99) begin errors++; $display("FAIL udf_q_hold got %h exp 99", q_b); end
        checks++; if (level_b !== 3'd0) begin errors++; $display("FAIL udf_level got %0d exp 0", level_b); end
        err_clr = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (underflow_b !== 1'b1) begin errors++; $display("FAIL udf_set_wins got %b exp 1", underflow_b); end
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        checks++; if (underflow_b !== 1'b0) begin errors++; $display("FAIL udf_clear got %b exp 0", underflow_b); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'(8'h51 + k));
        checks++; if (level_a !== 3'd4) begin errors++; $display("FAIL flush_pre_level got %0d exp 4", level_a); end
        flush = 1'b1;
        cyc(1'b1, 1'b0, 8'hEE);
        flush = 1'b0;
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level_a); end
        checks++; if (empty_b !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty_b); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b exp 0", overflow_a); end
        checks++; if (q_b !== 8'h99) begin errors++; $display("FAIL flush_q_hold got %h exp 99", q_b); end
        cyc(1'b1, 1'b0, 8'h61);
        checks++; if (level_a !== 3'd1) begin errors++; $display("FAIL flush_post_level got %0d exp 1", level_a); end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (q_b !== 8'h61) begin errors++; $display("FAIL flush_post_read got %h exp 61", q_b); end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h71);
        cyc(1'b1, 1'b0, 8'h72);
        wen  = 1'b1;
        data = 8'h73;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (level_a !== 3'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level_a); end
        checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL arst_empty got %b exp 1", empty_a); end
        checks++; if (q_a !== 8'h00) begin errors++; $display("FAIL arst_q_a got %h exp 00", q_a); end
        checks++; if (q_b !== 8'h00) begin errors++; $display("FAIL arst_q_b got %h exp 00", q_b); end
        checks++; if (underflow_a !== 1'b0) begin errors++; $display("FAIL arst_underflow got %b exp 0", underflow_a); end
        checks++; if (almost_empty_b !== 1'b1) begin errors++; $display("FAIL arst_almost_empty got %b exp 1", almost_empty_b); end
        #2;
        wen   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (level_b !== 3'd0) begin errors++; $display("FAIL arst_post_level got %0d exp 0", level_b); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_wrap();
        test_pass_through();
        test_bypass();
        test_underflow_clear();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
